// File: rtl/mul_issue_ctrl.sv
// Issue/completion controller for the fixed-latency 32x32 multiplier.
// Conditions RV32M operands, tracks tags in flight and buffers results under credit control.
module mul_issue_ctrl #(
  parameter int unsigned LAT   = 6,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       req_op_i,
  input  logic [31:0]      req_rs1_i,
  input  logic [31:0]      req_rs2_i,
  input  logic [TAG_W-1:0] req_tag_i,
  input  logic             flush_i,
  output logic             mul_start_o,
  output logic [31:0]      mul_rs1_o,
  output logic [31:0]      mul_rs2_o,
  input  logic [63:0]      mul_result_i,
  input  logic             mul_valid_i,
  output logic             rsp_valid_o,
  input  logic             rsp_ready_i,
  output logic [31:0]      rsp_data_o,
  output logic [TAG_W-1:0] rsp_tag_o,
  output logic             busy_o,
  output logic             err_o
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULH   = 2'b01;
  localparam logic [1:0] OP_MULHSU = 2'b10;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0 || LAT < 1) begin : g_bad_param
    $error("mul_issue_ctrl: DEPTH must be a power of 2 >= 2 and LAT >= 1");
  end

  typedef enum logic {RUN, DRAIN} state_t;

  state_t state_q, state_d;

  logic [CW-1:0] inflight_q, fifo_cnt_q, drop_q, drop_d;
  logic [CW:0]   credit_used;
  logic          accept, complete, drop_hit, spurious, rsp_pop;

  logic          sgn_a, sgn_b, neg_a, neg_b, neg_req;
  logic [31:0]   mag_a, mag_b;
  logic [63:0]   prod;
  logic [31:0]   res_data;

  logic [TAG_W-1:0] meta_tag [DEPTH];
  logic [1:0]       meta_op  [DEPTH];
  logic             meta_neg [DEPTH];
  logic [AW-1:0]    meta_wp, meta_rp;

  logic [31:0]      out_data [DEPTH];
  logic [TAG_W-1:0] out_tag  [DEPTH];
  logic [AW-1:0]    out_wp, out_rp;

  // Operand conditioning: signed operands are issued as magnitudes, sign fixed on completion
  assign sgn_a   = (req_op_i == OP_MULH) || (req_op_i == OP_MULHSU);
  assign sgn_b   = (req_op_i == OP_MULH);
  assign neg_a   = sgn_a & req_rs1_i[31];
  assign neg_b   = sgn_b & req_rs2_i[31];
  assign mag_a   = neg_a ? (~req_rs1_i + 32'd1) : req_rs1_i;
  assign mag_b   = neg_b ? (~req_rs2_i + 32'd1) : req_rs2_i;
  assign neg_req = neg_a ^ neg_b;

  assign credit_used = {1'b0, inflight_q} + {1'b0, fifo_cnt_q};

  assign accept   = req_valid_i & req_ready_o;
  assign drop_hit = mul_valid_i & (drop_q != '0);
  assign complete = mul_valid_i & (drop_q == '0) & (inflight_q != '0);
  assign spurious = mul_valid_i & (drop_q == '0) & (inflight_q == '0);

  assign prod     = meta_neg[meta_rp] ? (~mul_result_i + 64'd1) : mul_result_i;
  assign res_data = (meta_op[meta_rp] == OP_MUL) ? prod[31:0] : prod[63:32];

  assign rsp_valid_o = (fifo_cnt_q != '0);
  assign rsp_data_o  = rsp_valid_o ? out_data[out_rp] : '0;
  assign rsp_tag_o   = rsp_valid_o ? out_tag[out_rp] : '0;
  assign rsp_pop     = rsp_valid_o & rsp_ready_i;
  assign busy_o      = (inflight_q != '0) | (fifo_cnt_q != '0) | (drop_q != '0);

  // A product landing in the flush cycle is already gone, so it is not counted into drop_cnt
  always_comb begin
    drop_d = drop_q - CW'(drop_hit);
    if (flush_i) begin
      drop_d = drop_d + inflight_q - CW'(complete);
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= RUN;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (drop_d != '0) begin
      state_d = DRAIN;
    end else begin
      state_d = RUN;
    end
  end

  always_comb begin
    req_ready_o = 1'b0;
    if (!rst_i && state_q == RUN && !flush_i && credit_used < (CW+1)'(DEPTH)) begin
      req_ready_o = 1'b1;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      drop_q      <= '0;
      err_o       <= 1'b0;
      mul_start_o <= 1'b0;
      mul_rs1_o   <= '0;
      mul_rs2_o   <= '0;
      inflight_q  <= '0;
      fifo_cnt_q  <= '0;
      meta_wp     <= '0;
      meta_rp     <= '0;
      out_wp      <= '0;
      out_rp      <= '0;
    end else begin
      drop_q      <= drop_d;
      err_o       <= err_o | spurious;
      mul_start_o <= accept;
      mul_rs1_o   <= accept ? mag_a : '0;
      mul_rs2_o   <= accept ? mag_b : '0;
      if (flush_i) begin
        inflight_q <= '0;
        fifo_cnt_q <= '0;
        meta_wp    <= '0;
        meta_rp    <= '0;
        out_wp     <= '0;
        out_rp     <= '0;
      end else begin
        inflight_q <= inflight_q + CW'(accept) - CW'(complete);
        fifo_cnt_q <= fifo_cnt_q + CW'(complete) - CW'(rsp_pop);
        if (accept)   meta_wp <= meta_wp + AW'(1);
        if (complete) meta_rp <= meta_rp + AW'(1);
        if (complete) out_wp  <= out_wp + AW'(1);
        if (rsp_pop)  out_rp  <= out_rp + AW'(1);
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      meta_tag[meta_wp] <= req_tag_i;
      meta_op[meta_wp]  <= req_op_i;
      meta_neg[meta_wp] <= neg_req;
    end
    if (complete && !flush_i) begin
      out_data[out_wp] <= res_data;
      out_tag[out_wp]  <= meta_tag[meta_rp];
    end
  end

endmodule

// File: tb/tb_mul_issue_ctrl.sv
// Scoreboard bench for mul_issue_ctrl with a behavioural fixed-latency multiplier.
module tb_mul_issue_ctrl;
  localparam int unsigned LAT   = 6;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned TAG_W = 5;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid, req_ready_o;
  logic [1:0]       req_op;
  logic [31:0]      req_rs1, req_rs2;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             mul_start_o;
  logic [31:0]      mul_rs1_o, mul_rs2_o;
  logic [63:0]      mul_result_i;
  logic             mul_valid_i;
  logic             rsp_valid_o, rsp_ready;
  logic [31:0]      rsp_data_o;
  logic [TAG_W-1:0] rsp_tag_o;
  logic             busy_o, err_o;
  logic             inject;

  always #5 clk = ~clk;

  mul_issue_ctrl #(.LAT(LAT), .DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
    .clk_i(clk), .rst_i(rst),
    .req_valid_i(req_valid), .req_ready_o(req_ready_o), .req_op_i(req_op),
    .req_rs1_i(req_rs1), .req_rs2_i(req_rs2), .req_tag_i(req_tag),
    .flush_i(flush),
    .mul_start_o(mul_start_o), .mul_rs1_o(mul_rs1_o), .mul_rs2_o(mul_rs2_o),
    .mul_result_i(mul_result_i), .mul_valid_i(mul_valid_i),
    .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready),
    .rsp_data_o(rsp_data_o), .rsp_tag_o(rsp_tag_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  // Multiplier: samples the start strobe, presents the unsigned product LAT cycles later
  logic [LAT-1:0] pv;
  logic [63:0]    pp [LAT];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      pv <= '0;
    end else begin
      pv    <= {pv[LAT-2:0], mul_start_o};
      pp[0] <= {32'd0, mul_rs1_o} * {32'd0, mul_rs2_o};
      for (int i = 1; i < LAT; i++) pp[i] <= pp[i-1];
    end
  end
  assign mul_valid_i  = pv[LAT-1] | inject;
  assign mul_result_i = pp[LAT-1];

  function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, ps;
    longint unsigned ua, ub, pu;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    case (op)
      2'd0:    begin pu = ua * ub;          return pu[31:0];  end
      2'd1:    begin ps = sa * sb;          return ps[63:32]; end
      2'd2:    begin ps = sa * longint'(ub); return ps[63:32]; end
      default: begin pu = ua * ub;          return pu[63:32]; end
    endcase
  endfunction

  typedef struct packed {
    logic [31:0]      data;
    logic [TAG_W-1:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int checks = 0, failures = 0;
  int cyc = 0, n_acc = 0, n_mv = 0, last_acc_cyc = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: pops the expected queue on every response handshake, records accepts
  always @(negedge clk) begin
    if (mul_valid_i) n_mv++;
    if (rst || flush) begin
      q.delete();
    end else begin
      if (rsp_valid_o && rsp_ready) begin
        if (q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_rsp: got data %0h tag %0d expected no response", rsp_data_o, rsp_tag_o);
        end else begin
          e = q.pop_front();
          chk("rsp_data", 64'(rsp_data_o), 64'(e.data));
          chk("rsp_tag", 64'(rsp_tag_o), 64'(e.tag));
        end
      end
      if (req_valid && req_ready_o) begin
        q.push_back(exp_t'({ref_mul(req_op, req_rs1, req_rs2), req_tag}));
        n_acc++;
        last_acc_cyc = cyc;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b, input logic [TAG_W-1:0] t);
    bit ok;
    ok = 0;
    req_valid = 1'b1; req_op = op; req_rs1 = a; req_rs2 = b; req_tag = t;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (req_ready_o) begin ok = 1; break; end
    end
    tick();
    req_valid = 1'b0;
    if (!ok) begin
      checks++;
      failures++;
      $display("FAIL send_timeout: got no accept for tag %0d expected accept within 200 cycles", t);
    end
  endtask

  task automatic expect_rsp(input string nm, input logic [31:0] d, input logic [TAG_W-1:0] t);
    int n;
    n = 0;
    @(negedge clk);
    while (!(rsp_valid_o && rsp_ready) && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({nm, "_data"}, 64'(rsp_data_o), 64'(d));
    chk({nm, "_tag"}, 64'(rsp_tag_o), 64'(t));
    tick();
  endtask

  task automatic wait_idle(input string nm);
    int n;
    n = 0;
    while ((busy_o || q.size() != 0) && n < 300) begin
      tick();
      n++;
    end
    chk({nm, "_busy"}, 64'(busy_o), 64'd0);
    chk({nm, "_pending"}, 64'(q.size()), 64'd0);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(7))
      0: return 32'h0000_0000;
      1: return 32'h0000_0001;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return 32'h7FFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish before 1ms");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, a0, m0, n;
    bit seen;
    logic [31:0] exp4 [4];
    exp4[0] = 32'h0000_0000; exp4[1] = 32'hFFFF_FFFE; exp4[2] = 32'hFFFF_FFFF; exp4[3] = 32'h4000_0000;

    rst = 1'b0; req_valid = 1'b0; req_op = '0; req_rs1 = '0; req_rs2 = '0; req_tag = '0;
    flush = 1'b0; rsp_ready = 1'b0; inject = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", 64'(req_ready_o), 64'd0);
    chk("reset_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("reset_busy", 64'(busy_o), 64'd0);
    chk("reset_err", 64'(err_o), 64'd0);
    chk("reset_mul_start", 64'(mul_start_o), 64'd0);
    rst = 1'b0;
    tick();
    chk("post_reset_ready", 64'(req_ready_o), 64'd1);

    // Single MUL with latency measurement
    rsp_ready = 1'b1;
    send(2'b00, 32'd3, 32'hFFFF_FFFB, 5'd5);
    lat = -1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (rsp_valid_o) begin lat = cyc - last_acc_cyc; break; end
    end
    chk("t1_latency", 64'(lat), 64'(LAT + 2));
    chk("t1_data", 64'(rsp_data_o), 64'h0000_0000_FFFF_FFF1);
    chk("t1_tag", 64'(rsp_tag_o), 64'd5);
    tick();

    // Back-to-back sign-correction corners
    n = cyc;
    send(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd0);
    send(2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd1);
    send(2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2);
    send(2'b01, 32'h8000_0000, 32'h8000_0000, 5'd3);
    chk("b2b_cycles", 64'(cyc - n), 64'd4);
    for (int k = 0; k < 4; k++) expect_rsp("b2b", exp4[k], TAG_W'(k));
    wait_idle("b2b");

    // Credit limit with the consumer stalled
    rsp_ready = 1'b0;
    a0 = n_acc;
    fork
      begin
        for (int i = 0; i < 6; i++) send(2'b00, 32'(i + 1), 32'd10, TAG_W'(8 + i));
      end
      begin
        repeat (20) tick();
        chk("credit_accepted", 64'(n_acc - a0), 64'(DEPTH));
        chk("credit_ready_low", 64'(req_ready_o), 64'd0);
        rsp_ready = 1'b1;
      end
    join
    wait_idle("credit");
    chk("credit_total", 64'(n_acc - a0), 64'd6);

    // Flush with three ops in flight
    send(2'b00, 32'd11, 32'd12, 5'd1);
    send(2'b01, 32'd13, 32'd14, 5'd2);
    send(2'b11, 32'd15, 32'd16, 5'd3);
    repeat (2) tick();
    m0 = n_mv;
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    chk("drain_ready_low", 64'(req_ready_o), 64'd0);
    chk("drain_busy", 64'(busy_o), 64'd1);
    seen = 0;
    n = 0;
    while (busy_o && n < 60) begin
      if (rsp_valid_o) seen = 1;
      tick();
      n++;
    end
    chk("drain_no_rsp", 64'(seen), 64'd0);
    chk("drain_discarded", 64'(n_mv - m0), 64'd3);
    chk("drain_done_ready", 64'(req_ready_o), 64'd1);
    send(2'b00, 32'd7, 32'd6, 5'd9);
    expect_rsp("post_flush", 32'd42, 5'd9);
    chk("post_flush_err", 64'(err_o), 64'd0);

    // Randomized traffic with occasional flushes
    for (int i = 0; i < 400; i++) begin
      rsp_ready = ($urandom_range(3) != 0);
      flush     = ($urandom_range(79) == 0);
      req_valid = ($urandom_range(2) != 0);
      req_op    = 2'($urandom_range(3));
      req_rs1   = pick();
      req_rs2   = pick();
      req_tag   = TAG_W'($urandom);
      tick();
    end
    flush = 1'b0;
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    wait_idle("random");
    chk("random_err", 64'(err_o), 64'd0);

    // Spurious product while idle
    inject = 1'b1;
    tick();
    inject = 1'b0;
    tick();
    chk("spurious_err", 64'(err_o), 64'd1);
    repeat (5) tick();
    chk("spurious_err_sticky", 64'(err_o), 64'd1);
    chk("spurious_no_rsp", 64'(rsp_valid_o), 64'd0);
    chk("spurious_busy", 64'(busy_o), 64'd0);

    // Asynchronous reset with two ops in flight
    send(2'b00, 32'd5, 32'd5, 5'd4);
    send(2'b00, 32'd6, 32'd6, 5'd5);
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_busy", 64'(busy_o), 64'd0);
    chk("arst_ready", 64'(req_ready_o), 64'd0);
    chk("arst_rsp_valid", 64'(rsp_valid_o), 64'd0);
    chk("arst_err", 64'(err_o), 64'd0);
    chk("arst_mul_rs1", 64'(mul_rs1_o), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    seen = 0;
    for (int i = 0; i < LAT + 6; i++) begin
      if (rsp_valid_o) seen = 1;
      tick();
    end
    chk("arst_no_rsp", 64'(seen), 64'd0);
    chk("arst_idle", 64'(busy_o), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/mul_issue_ctrl.md
Name: mul_issue_ctrl

Overview:
- Sequences the 32x32 pipelined multiplier for the integer ALU.
- Accepts RV32M multiply ops (MUL/MULH/MULHSU/MULHU) over a valid/ready handshake.
- Sign-corrects operands and results, and tracks destination tags through the fixed-latency multiplier.
- Buffers results in an output FIFO; credit control guarantees no multiplier result is ever dropped, since the multiplier cannot stall.

Parameters:
- LAT, 6: cycles from mul_start_o high to the matching mul_valid_i high.
- DEPTH, 4: max ops in flight plus ops buffered in the output FIFO (power of 2, >= 2).
- TAG_W, 5: width of the destination tag.

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  asynchronous active-high reset
- req_valid_i  in  1  op request valid
- req_ready_o  out  1  controller can accept op
- req_op_i  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU
- req_rs1_i  in  32  operand A
- req_rs2_i  in  32  operand B
- req_tag_i  in  TAG_W  destination tag
- flush_i  in  1  kill all in-flight and buffered ops
- mul_start_o  out  1  multiplier start strobe
- mul_rs1_o  out  32  unsigned magnitude of A
- mul_rs2_o  out  32  unsigned magnitude of B
- mul_result_i  in  64  unsigned product
- mul_valid_i  in  1  product valid
- rsp_valid_o  out  1  result valid
- rsp_ready_i  in  1  consumer accepts result
- rsp_data_o  out  32  selected 32-bit result
- rsp_tag_o  out  TAG_W  tag of result
- busy_o  out  1  any op in flight, buffered, or being dropped
- err_o  out  1  sticky: unexpected mul_valid_i

Behaviour:
- Reset (async, any time, including mid-operation):
  - All outputs 0; FIFOs empty; counters 0; FSM = RUN.
  - The multiplier shares rst_i, so no stale results survive reset.
- Accept:
  - An op is accepted on a rising edge with req_valid_i & req_ready_o.
  - req_ready_o = (FSM==RUN) & !flush_i & (inflight + fifo_count < DEPTH).
- Operand conditioning:
  - sgnA = op in {MULH, MULHSU}; sgnB = op == MULH.
  - magA = (sgnA & A[31]) ? -A : A; magB likewise. Take the unsigned 32-bit two's-complement; 0x80000000 maps to 0x80000000.
  - neg = (sgnA & A[31]) ^ (sgnB & B[31]).
- Issue:
  - At the accept edge T, register mul_start_o=1 and mul_rs1_o/mul_rs2_o for exactly one cycle (cycle T+1).
  - At the same edge, push {tag, op, neg} into the metadata FIFO (depth DEPTH); inflight increments.
- Completion (edge where mul_valid_i=1 and drop_cnt==0, metadata FIFO non-empty):
  - Pop metadata; p = neg ? -mul_result_i : mul_result_i (64-bit).
  - data = (op==MUL) ? p[31:0] : p[63:32].
  - Push {tag, data} into the output FIFO; inflight decrements.
- Latency: accept edge T -> mul_start_o at T+1 -> mul_valid_i LAT cycles later -> rsp_valid_o one cycle after that. Total is LAT+2 cycles with an empty FIFO.
- Back-to-back: one accept per cycle is sustained while credits remain.
- Simultaneous accept and completion in the same cycle: both counters update correctly, with net inflight unchanged.
- Output:
  - rsp_valid_o = FIFO non-empty; rsp_data_o/rsp_tag_o = FIFO head.
  - Pop on rsp_valid_o & rsp_ready_i.
  - Results return in acceptance order.
  - A simultaneous push and pop on a full FIFO is legal; the credit rule prevents overflow.
- FSM:
  - RUN: normal operation.
  - flush_i=1 (any state):
    - Output FIFO and metadata FIFO are cleared.
    - drop_cnt = current inflight, excluding any accept in the same cycle (none, because ready is low).
    - inflight = 0.
    - Go to DRAIN if drop_cnt is nonzero, else stay in RUN.
  - DRAIN:
    - req_ready_o=0; each mul_valid_i decrements drop_cnt and its result is discarded.
    - Return to RUN on the edge where drop_cnt reaches 0.
  - A flush during DRAIN keeps the existing drop_cnt, because inflight is already 0.
- Error:
  - mul_valid_i while metadata FIFO is empty and drop_cnt==0 sets err_o=1.
  - The result is discarded; err_o is cleared only by reset.
- busy_o = (inflight != 0) | (fifo_count != 0) | (drop_cnt != 0).

Test Plan:
- MUL A=3, B=0xFFFFFFFB (-5), rsp_ready=1 -> rsp_data=0xFFFFFFF1, tag echoed, rsp_valid exactly LAT+2 cycles after accept.
- Four ops (LAT=6) back-to-back:
  - MULH 0xFFFFFFFF x 0xFFFFFFFF -> 0x00000000
  - MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE
  - MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF
  - MULH 0x80000000 x 0x80000000 -> 0x40000000
  - Results arrive in order with tags 0..3.
- DEPTH=4, rsp_ready=0, 6 requests held valid -> exactly 4 accepted, then req_ready=0. Raise rsp_ready -> 4 results drain in order, remaining 2 accepted.
- Issue 3 ops, assert flush_i 2 cycles later -> FSM enters DRAIN, req_ready=0, 3 mul_valid pulses discarded, no rsp_valid. Returns to RUN, and a new MUL 7x6 -> 42.
- Inject a spurious mul_valid_i when idle -> err_o=1 and sticky; rsp_valid stays 0.
- Assert rst_i asynchronously mid-op with 2 in flight -> all outputs 0 immediately, no response after release, busy_o=0.
